// File: rtl/dcache_pkg.sv
//============================================================
// dcache_pkg -- shared types and geometry for the data cache
// Rev 1.0
//============================================================
`default_nettype none

package dcache_pkg;

  localparam int OFFSET_BITS    = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = 128;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WB_REQ    = 2'd1,
    FILL_REQ  = 2'd2,
    FILL_WAIT = 2'd3
  } state_e;

  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0]        sel);
    logic [31:0] w;
    w = line[31:0];
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      if (sel == 2'(k)) w = line[k*32 +: 32];
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_data_array.sv
//============================================================
// dcache_data_array -- LINES x 128-bit line store, one write port
// Rev 1.0
//============================================================
`default_nettype none

module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX   = 6
) (
  input  logic              clk,
  input  logic [IDX-1:0]    idx_i,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              fill_we_i,
  input  logic [LINE_W-1:0] fill_line_i,
  input  logic              word_we_i,
  input  logic [1:0]        word_sel_i,
  input  logic [3:0]        byte_en_i,
  input  logic [31:0]       word_data_i
);

  logic [LINE_W-1:0] mem_q [LINES];
  logic [LINE_W-1:0] merged_line;

  assign rd_line_o = mem_q[idx_i];

  // A store hit rewrites the whole line with only the enabled byte lanes changed.
  always_comb begin
    merged_line = mem_q[idx_i];
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (word_sel_i == 2'(w) && byte_en_i[b]) begin
          merged_line[w*32 + b*8 +: 8] = word_data_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we_i) begin
      mem_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      mem_q[idx_i] <= merged_line;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
//============================================================
// dcache_ctrl -- blocking direct-mapped write-back/allocate D-cache
// Rev 1.0
//============================================================
`default_nettype none

module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAG_W = 28 - $clog2(LINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [27:0]       mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data
);

  localparam int IDX = $clog2(LINES);

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [31:0]       dout_q;

  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [1:0]        word_sel;
  logic              is_write;
  logic              active;
  logic              hit;
  logic              victim_dirty;
  logic [LINE_W-1:0] line_rd;

  logic              dout_load;
  logic              word_we;
  logic              set_dirty;
  logic              clr_dirty;
  logic              fill_done;

  wire unused_addr_lsbs = ^dcache_addr[1:0];

  assign idx          = dcache_addr[IDX+OFFSET_BITS-1:OFFSET_BITS];
  assign addr_tag     = dcache_addr[31:IDX+OFFSET_BITS];
  assign word_sel     = dcache_addr[3:2];
  assign is_write     = |dcache_we;
  assign active       = dcache_re | is_write;
  assign hit          = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];

  assign stall        = (state_q != IDLE) | (active & ~hit);
  assign dcache_dout  = dout_q;

  dcache_data_array #(
    .LINES (LINES),
    .IDX   (IDX)
  ) u_data (
    .clk         (clk),
    .idx_i       (idx),
    .rd_line_o   (line_rd),
    .fill_we_i   (fill_done),
    .fill_line_i (mem_resp_data),
    .word_we_i   (word_we),
    .word_sel_i  (word_sel),
    .byte_en_i   (dcache_we),
    .word_data_i (dcache_din)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = dcache_addr[31:OFFSET_BITS];
    mem_req_data  = '0;
    dout_load     = 1'b0;
    word_we       = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    fill_done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (active) begin
          if (hit) begin
            // A store takes priority over a simultaneous load.
            if (is_write) begin
              word_we   = 1'b1;
              set_dirty = 1'b1;
            end else begin
              dout_load = 1'b1;
            end
          end else begin
            state_d = victim_dirty ? WB_REQ : FILL_REQ;
          end
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_q[idx], idx};
        mem_req_data  = line_rd;
        if (mem_req_ready) begin
          clr_dirty = 1'b1;
          state_d   = FILL_REQ;
        end
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_resp_valid) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (dout_load) dout_q <= line_word(line_rd, word_sel);
      if (set_dirty) dirty_q[idx] <= 1'b1;
      if (clr_dirty) dirty_q[idx] <= 1'b0;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tags need no reset: valid gates every comparison.
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[idx] <= addr_tag;
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
//============================================================
// tb_dcache_ctrl -- directed table plus randomized model check
// Rev 1.0
//============================================================
`default_nettype none

module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  dcache_addr;
  logic         dcache_re;
  logic [3:0]   dcache_we;
  logic [31:0]  dcache_din;
  logic [31:0]  dcache_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory images ----------------
  logic [127:0] mmem [logic [27:0]];
  logic [31:0]  arch [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    if (wa[29:2] == 28'h10) return 32'h11111111 * (32'(wa[1:0]) + 32'd1);
    return {wa[25:2], 6'h2A, wa[1:0]} ^ 32'h5A000000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    if (mmem.exists(la)) return mmem[la];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = init_word({la, 2'(k)});
    return l;
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] wa);
    if (arch.exists(wa)) return arch[wa];
    return init_word(wa);
  endfunction

  task automatic ref_write(input logic [29:0] wa, input logic [3:0] we, input logic [31:0] din);
    logic [31:0] w;
    w = ref_read(wa);
    for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = din[b*8 +: 8];
    arch[wa] = w;
  endtask

  // ---------------- memory responder ----------------
  logic         auto_resp  = 1'b1;
  logic         force_resp = 1'b0;
  logic [127:0] force_data = '0;
  int           block_req  = 0;
  int           blk_seen   = 0;
  logic         resp_pending = 1'b0;
  logic [127:0] resp_line = '0;
  logic [27:0]  fill_addr_log = '0;
  logic [27:0]  wb_addr_log = '0;
  logic [127:0] wb_data_log = '0;
  int           wb_cnt = 0;
  int           fill_cnt = 0;

  initial begin
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = resp_pending | force_resp;
      mem_resp_data  = force_resp ? force_data : resp_line;
      resp_pending   = 1'b0;
      if (mem_req_valid && !mem_req_rw && blk_seen < block_req) begin
        mem_req_ready = 1'b0;
        blk_seen++;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_rw) begin
          mmem[mem_req_addr] = mem_req_data;
          wb_addr_log = mem_req_addr;
          wb_data_log = mem_req_data;
          wb_cnt++;
        end else begin
          fill_addr_log = mem_req_addr;
          fill_cnt++;
          resp_line    = mem_line(mem_req_addr);
          resp_pending = auto_resp;
          blk_seen     = 0;
        end
      end
    end
  end

  // One core access held until accepted; returns stall cycles and dout afterwards.
  task automatic access(input logic [31:0] a, input logic re, input logic [3:0] we,
                        input logic [31:0] din, output int ncyc, output logic [31:0] dout_after);
    logic [31:0]  d0;
    logic         pv, pr, prw;
    logic [27:0]  pa;
    logic [127:0] pd;
    @(negedge clk);
    dcache_addr = a; dcache_re = re; dcache_we = we; dcache_din = din;
    #1;
    d0 = dcache_dout;
    ncyc = 0;
    while (stall && ncyc < 200) begin
      pv = mem_req_valid; pr = mem_req_ready; prw = mem_req_rw;
      pa = mem_req_addr;  pd = mem_req_data;
      @(negedge clk); #1;
      ncyc++;
      check("dout_hold_in_stall", 160'(dcache_dout), 160'(d0));
      if (pv && !pr) begin
        check("req_stable_valid", 160'(mem_req_valid), 160'(pv));
        check("req_stable_fields", {2'b0, mem_req_rw, mem_req_addr, mem_req_data},
              {2'b0, prw, pa, pd});
      end
    end
    if (stall) begin
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, ncyc);
    end
    @(negedge clk);
    dcache_re = 1'b0; dcache_we = 4'b0;
    #1;
    dout_after = dcache_dout;
  endtask

  // Direct-mapped residency model used to predict stall length.
  logic [27:0] res_line [64];
  bit          res_v [64];
  bit          res_d [64];

  function automatic int model_access(input logic [31:0] a, input bit wr, input int blk);
    int i;
    int c;
    i = int'(a[9:4]);
    if (res_v[i] && res_line[i] == a[31:4]) c = 0;
    else begin
      c = (res_v[i] && res_d[i]) ? 4 + blk : 3 + blk;
      res_v[i] = 1; res_d[i] = 0; res_line[i] = a[31:4];
    end
    if (wr) res_d[i] = 1;
    return c;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] din;
    int          blk;
    int          exp_cyc;
    logic [31:0] exp_dout;
    logic        chk_fill;
    logic [27:0] exp_fill;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int          ncyc;
    logic [31:0] dv;
    logic [31:0] exp_dout;
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] din;
    logic        re;
    int          blk;
    int          expc;
    int          fc0;

    tbl[0] = '{32'h104, 1'b1, 4'b0000, 32'h0,        0, 3, 32'h22222222, 1'b1, 28'h10};
    tbl[1] = '{32'h100, 1'b1, 4'b0000, 32'h0,        0, 0, 32'h11111111, 1'b0, 28'h0};
    tbl[2] = '{32'h108, 1'b0, 4'b0010, 32'h0000AB00, 0, 0, 32'h11111111, 1'b0, 28'h0};
    tbl[3] = '{32'h108, 1'b1, 4'b0000, 32'h0,        0, 0, 32'h3333AB33, 1'b0, 28'h0};
    tbl[4] = '{32'h500, 1'b1, 4'b0000, 32'h0,        0, 4, init_word(30'h140), 1'b1, 28'h50};
    tbl[5] = '{32'h904, 1'b1, 4'b0000, 32'h0,        5, 8, init_word(30'h241), 1'b1, 28'h90};

    reset = 1'b1; dcache_addr = '0; dcache_re = 1'b0; dcache_we = '0; dcache_din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_stall", 160'(stall), 160'(0));
    check("reset_req_valid", 160'(mem_req_valid), 160'(0));
    check("reset_dout", 160'(dcache_dout), 160'(0));

    foreach (tbl[i]) begin
      block_req = tbl[i].blk;
      access(tbl[i].addr, tbl[i].re, tbl[i].we, tbl[i].din, ncyc, dv);
      block_req = 0;
      if (tbl[i].we != 4'b0) ref_write(tbl[i].addr[31:2], tbl[i].we, tbl[i].din);
      check($sformatf("vec%0d_stall_cycles", i), 160'(ncyc), 160'(tbl[i].exp_cyc));
      check($sformatf("vec%0d_dout", i), 160'(dv), 160'(tbl[i].exp_dout));
      if (tbl[i].chk_fill)
        check($sformatf("vec%0d_fill_addr", i), 160'(fill_addr_log), 160'(tbl[i].exp_fill));
    end
    check("wb_count", 160'(wb_cnt), 160'(1));
    check("wb_addr", 160'(wb_addr_log), 160'(28'h10));
    check("wb_word2", 160'(wb_data_log[95:64]), 160'(32'h3333AB33));

    // Reset while waiting for a fill; the late response must be discarded.
    auto_resp = 1'b0;
    @(negedge clk);
    dcache_addr = 32'h104; dcache_re = 1'b1;
    @(negedge clk); #1;
    check("rst_fill_req", {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, 1'b0, 28'h10});
    @(negedge clk); #1;
    check("rst_fill_wait", {mem_req_valid, stall}, {1'b0, 1'b1});
    reset = 1'b1; dcache_re = 1'b0;
    @(negedge clk);
    reset = 1'b0; force_resp = 1'b1; force_data = {4{32'hDEADBEEF}};
    #1;
    check("rst_idle_stall", 160'(stall), 160'(0));
    check("rst_idle_dout", 160'(dcache_dout), 160'(0));
    @(negedge clk);
    force_resp = 1'b0;
    auto_resp  = 1'b1;
    foreach (res_v[i]) begin res_v[i] = 0; res_d[i] = 0; end
    fc0 = fill_cnt;
    expc = model_access(32'h104, 0, 0);
    access(32'h104, 1'b1, 4'b0, 32'h0, ncyc, dv);
    check("reread_misses", 160'(ncyc), 160'(expc));
    check("reread_fill_issued", 160'(fill_cnt - fc0), 160'(1));
    check("reread_dout", 160'(dv), 160'(ref_read(30'h41)));
    exp_dout = dv;

    // Randomized traffic over a few conflicting lines, including the top of memory.
    for (int n = 0; n < 300; n++) begin
      logic [21:0] t;
      case ($urandom_range(0, 3))
        0: t = 22'h0;
        1: t = 22'h1;
        2: t = 22'h2;
        default: t = 22'h3FFFFF;
      endcase
      a = {t, 6'($urandom_range(16, 19)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      din = $urandom;
      case ($urandom_range(0, 3))
        0, 1: begin re = 1'b1; we = 4'b0; end
        2:    begin re = 1'b0; we = 4'($urandom_range(1, 15)); end
        default: begin re = 1'b1; we = 4'($urandom_range(1, 15)); end
      endcase
      blk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      expc = model_access(a, we != 4'b0, blk);
      block_req = blk;
      access(a, re, we, din, ncyc, dv);
      block_req = 0;
      if (we != 4'b0) ref_write(a[31:2], we, din);
      else exp_dout = ref_read(a[31:2]);
      check($sformatf("rnd%0d_stall_cycles", n), 160'(ncyc), 160'(expc));
      check($sformatf("rnd%0d_dout", n), 160'(dv), 160'(exp_dout));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Blocking, direct-mapped, write-back, write-allocate data cache that sits directly downstream of the 3-stage core's data-memory port. It consumes the core's `dcache_addr`/`dcache_re`/`dcache_we`/`dcache_din` and returns `dcache_dout` one cycle after a hit. On a miss it produces the core's `stall`, and refills or evicts 128-bit lines over a valid/ready main-memory port.

## Interface
- `LINES`, default 64: number of lines, power of 2; index width `IDX = log2(LINES)`.
- `TAG_W`, default `28 - IDX`: tag width (32 address bits − 4 offset bits − IDX).
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `dcache_addr` input 32: byte address; bits [1:0] ignored; [3:2] word in line; [IDX+3:4] index; [31:IDX+4] tag.
- `dcache_re` input 1: read request.
- `dcache_we` input 4: byte write mask; nonzero means write request.
- `dcache_din` input 32: store data, already lane-aligned.
- `dcache_dout` output 32: read data.
- `stall` output 1: core must freeze and hold all request inputs.
- `mem_req_valid` output 1: memory request valid.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_rw` output 1: 1 = line write, 0 = line read.
- `mem_req_addr` output 28: line address (byte address [31:4]).
- `mem_req_data` output 128: writeback line; word 0 is in [31:0].
- `mem_resp_valid` input 1: fill data valid, single beat.
- `mem_resp_data` input 128: fill line.

## Operation
- A request is active when `dcache_re` is high or `dcache_we` is nonzero.
  - If both are present, the write wins and `re` is ignored.
- Hit: `valid[idx]` is set and `tag[idx]` equals the address tag, evaluated combinationally in IDLE.
- Read hit: the word is captured into `dcache_dout` at the clock edge.
- Write hit: the masked bytes are merged into the line and `dirty[idx]` is set. `dcache_dout` is unchanged.
- `dcache_dout` holds its last value until the next accepted read hit. It must stay stable through stalls, because the core's writeback stage may re-sample it.
- Miss: the FSM leaves IDLE and the request is replayed in IDLE after the refill.
- FSM states:
  - IDLE:
    - On a miss with a dirty valid victim, go to WB_REQ.
    - On a miss with a clean or invalid victim, go to FILL_REQ.
  - WB_REQ:
    - Drives `mem_req_valid=1`, `rw=1`, `addr={victim tag, idx}`, `data=victim line`.
    - On `valid & ready`, clear `dirty[idx]` and go to FILL_REQ.
  - FILL_REQ:
    - Drives `mem_req_valid=1`, `rw=0`, `addr=dcache_addr[31:4]`.
    - On `valid & ready`, go to FILL_WAIT.
  - FILL_WAIT:
    - On `mem_resp_valid`, write the line, set valid, clear dirty, load the tag, and go to IDLE.
- `stall = (state != IDLE) | (active & miss)`; it is combinational.
- `mem_req_*` outputs are stable while valid is high and not yet accepted.
- `mem_resp_valid` is ignored outside FILL_WAIT.
- No read-during-write forwarding is needed: the core never issues back-to-back dependent accesses in one cycle.

## Timing
- Reset values: state IDLE, all `valid`/`dirty` cleared, `dcache_dout=0`, `mem_req_valid=0`, and `stall=0` while no request is active.
- Data array contents are not reset.
- Read hit accepted at cycle N: `dcache_dout` is valid from N+1, and `stall` stays low.
- Clean miss detected at N, with `ready=1` and response one cycle after acceptance:
  - FILL_REQ at N+1.
  - `resp_valid` at N+2.
  - IDLE hit at N+3.
  - `stall` is high for N..N+2, and `dout` is valid at N+4.
- A dirty miss adds one cycle plus any ready backpressure. Each cycle `mem_req_ready` is low extends the stall by one cycle.
- Reset mid-miss returns the FSM to IDLE on the next edge and invalidates all lines. A late `mem_resp_valid` is dropped.
- A tag/index wrap across the full address space needs no special handling.

## Structure
- The `dcache_pkg` package holds:
  - the state enum (IDLE, WB_REQ, FILL_REQ, FILL_WAIT);
  - `OFFSET_BITS=4`;
  - `WORDS_PER_LINE=4`;
  - `LINE_W=128`.
- Sub-module `dcache_data_array` has `LINES x 128` storage, a combinational line read for writeback, and one write port. The write port accepts either a full line (fill) or a word with a 4-bit byte mask (store hit).
- Tags, valid and dirty bits live in flops in `dcache_ctrl`.

## Test plan
- Reset, then idle: `stall=0`, `mem_req_valid=0`, `dcache_dout=0`.
- Cold read of 0x104, with memory returning line 0x44444444_33333333_22222222_11111111:
  - `mem_req_addr=0x0000010`, `rw=0`.
  - `stall` is high for 3 cycles.
  - `dcache_dout=0x22222222`.
  - A following read of 0x100 hits with `stall` low and returns 0x11111111.
- Write 0x108 with `we=4'b0010`, `din=0x0000AB00` after the fill: `stall` stays low, and reading 0x108 returns 0x3333AB33.
- Then read 0x500 (same index, `LINES=64`):
  - Writeback issues `rw=1`, `addr=0x0000010`, with data word 2 = 0x3333AB33.
  - The fill then issues `addr=0x0000050`.
- Hold `mem_req_ready=0` for 5 cycles during FILL_REQ: `mem_req_*` stay stable, `stall` stays high, and `dout` keeps its previous value.
- Assert `reset` in FILL_WAIT, then pulse `mem_resp_valid`: the response is ignored, and a re-read of 0x104 misses again.
